// File: rtl/core_pkg.sv
// Shared fetch-path types and constants.
package core_pkg;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One fetch queue slot: PC captured at issue, instruction captured at response.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_slot_array.sv
// Storage for the in-order fetch queue: PC written at issue, instruction at
// response, filled bit cleared on consume or flush. Head slot read combinationally.
module fetch_slot_array
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [IW-1:0]   alloc_idx,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_en,
    input  logic [IW-1:0]   fill_idx,
    input  logic [ILEN-1:0] fill_inst,
    input  logic            clear_en,
    input  logic [IW-1:0]   clear_idx,
    input  logic [IW-1:0]   head_idx,
    output fq_entry_t       head_entry
);

    fq_entry_t slots [DEPTH];

    // Slot updates; alloc, fill and clear never target the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                slots[alloc_idx].pc <= alloc_pc;
            end
            if (fill_en) begin
                slots[fill_idx].inst   <= fill_inst;
                slots[fill_idx].filled <= 1'b1;
            end
            if (clear_en) begin
                slots[clear_idx].filled <= 1'b0;
            end
        end
    end

    assign head_entry = slots[head_idx];

endmodule

// File: rtl/fetch_queue_ifu.sv
// Fetch unit: PC generator, DEPTH-entry in-order fetch queue, credit-limited
// request issue and drop counting for responses orphaned by a redirect.
// XLEN/ILEN must match core_pkg because the slot struct is sized from it.
module fetch_queue_ifu
    import core_pkg::*;
#(
    parameter int              XLEN_P   = core_pkg::XLEN,
    parameter int              ILEN_P   = core_pkg::ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    localparam int             PW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN_P-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [XLEN_P-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [ILEN_P-1:0] imem_rsp_data,
    output logic              id_valid,
    output logic [ILEN_P-1:0] id_inst,
    output logic [XLEN_P-1:0] id_pc,
    input  logic              id_ready,
    output logic [PW-1:0]     occupancy
);

    localparam int          IW      = PW - 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

    logic [PW-1:0]     alloc_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     drop_cnt;
    logic [XLEN_P-1:0] fetch_pc;

    logic [PW-1:0]     in_flight;
    logic [PW:0]       credit_used;
    logic              accept;
    logic              rsp_drop;
    logic              rsp_fill;
    logic              consume;
    logic [PW-1:0]     drop_on_redirect;
    fq_entry_t         head_entry;

    assign occupancy   = alloc_ptr - head_ptr;
    assign in_flight   = alloc_ptr - fill_ptr;
    assign credit_used = {1'b0, occupancy} + {1'b0, drop_cnt};

    // Outstanding drops consume credit so a redirect cannot overrun the memory side.
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

    assign id_valid = head_entry.filled;
    assign id_inst  = head_entry.filled ? head_entry.inst : NOP_INST;
    assign id_pc    = head_entry.filled ? head_entry.pc : '0;
    assign consume  = head_entry.filled && id_ready && !redirect_valid;

    // Every issued-but-unfilled request becomes a drop; a response this cycle retires one.
    assign drop_on_redirect = drop_cnt + in_flight - PW'(imem_rsp_valid);

    fetch_slot_array #(
        .DEPTH(DEPTH)
    ) u_slots (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .alloc_en  (accept),
        .alloc_idx (alloc_ptr[IW-1:0]),
        .alloc_pc  (fetch_pc),
        .fill_en   (rsp_fill),
        .fill_idx  (fill_ptr[IW-1:0]),
        .fill_inst (imem_rsp_data),
        .clear_en  (consume),
        .clear_idx (head_ptr[IW-1:0]),
        .head_idx  (head_ptr[IW-1:0]),
        .head_entry(head_entry)
    );

    // Pointer, PC and drop-counter state; redirect overrides all other updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            fetch_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= drop_on_redirect;
            fetch_pc  <= redirect_pc;
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + PW'(1);
                fetch_pc  <= fetch_pc + XLEN_P'(4);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (rsp_fill) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (consume) begin
                head_ptr <= head_ptr + PW'(1);
            end
        end
    end

    // A response must correspond to a pending drop or an issued, unfilled slot.
    assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((drop_cnt != '0) || (alloc_ptr != fill_ptr)));

endmodule

// File: tb/tb_fetch_queue_ifu.sv
module tb_fetch_queue_ifu;
    import core_pkg::*;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        id_ready;
    logic [2:0]  occupancy;

    int          n_vec = 0;
    int          n_err = 0;
    logic        rsp_en;
    logic [63:0] pend_q[$];

    fetch_queue_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_ready      (id_ready),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record accepts before the edge, then present the next in-order response.
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) pend_q.push_back(imem_req_addr);
        @(posedge clk);
        #1;
        if (rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (rsp_en && pend_q.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0; rsp_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr",  imem_req_addr, 64'd0);
        chk("rst_id_valid",  64'(id_valid), 64'd0);
        chk("rst_id_inst",   64'(id_inst), 64'(NOP_INST));
        chk("rst_id_pc",     id_pc, 64'd0);
        chk("rst_occ",       64'(occupancy), 64'd0);
        tick(); tick();

        // Reset release and fill with decoder stalled
        rst = 1'b0; #1;
        chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_addr0", imem_req_addr, B);
        chk("t1_occ0", 64'(occupancy), 64'd0);
        tick(); #1;
        chk("t1_addr1", imem_req_addr, B + 64'h4);
        chk("t1_occ1", 64'(occupancy), 64'd1);
        chk("t1_idv1", 64'(id_valid), 64'd0);
        tick(); #1;
        chk("t1_idv2", 64'(id_valid), 64'd1);
        chk("t1_idpc2", id_pc, B);
        chk("t1_idinst2", 64'(id_inst), 64'(inst_of(B)));
        chk("t1_occ2", 64'(occupancy), 64'd2);
        chk("t1_addr2", imem_req_addr, B + 64'h8);
        tick(); #1;
        chk("t2_occ3", 64'(occupancy), 64'd3);
        chk("t2_addr3", imem_req_addr, B + 64'hC);
        tick(); #1;
        chk("t2_full_occ", 64'(occupancy), 64'd4);
        chk("t2_full_req", 64'(imem_req_valid), 64'd0);
        chk("t2_full_addr", imem_req_addr, 64'd0);
        tick();
        id_ready = 1'b1; #1;
        chk("t2_pop_req", 64'(imem_req_valid), 64'd0);
        chk("t2_pop_pc0", id_pc, B);
        tick(); #1;
        chk("t2_resume_req", 64'(imem_req_valid), 64'd1);
        chk("t2_resume_addr", imem_req_addr, B + 64'h10);
        chk("t2_pop_pc1", id_pc, B + 64'h4);
        chk("t2_occ_after", 64'(occupancy), 64'd3);
        tick();
        rsp_en = 1'b0; #1;
        chk("t2_pop_pc2", id_pc, B + 64'h8);
        chk("t2_addr5", imem_req_addr, B + 64'h14);
        tick(); #1;
        chk("t2_pop_pc3", id_pc, B + 64'hC);
        chk("t2_addr6", imem_req_addr, B + 64'h18);
        chk("t2_occ6", 64'(occupancy), 64'd3);
        tick();

        // Redirect with two requests in flight and no response that cycle
        redirect_valid = 1'b1; redirect_pc = B + 64'h100; id_ready = 1'b0; #1;
        chk("t3_redir_req", 64'(imem_req_valid), 64'd0);
        chk("t3_redir_idv", 64'(id_valid), 64'd1);
        tick();
        redirect_valid = 1'b0; rsp_en = 1'b1; id_ready = 1'b1; #1;
        chk("t3_drop2", 64'(dut.drop_cnt), 64'd2);
        chk("t3_occ0", 64'(occupancy), 64'd0);
        chk("t3_idv0", 64'(id_valid), 64'd0);
        chk("t3_addr100", imem_req_addr, B + 64'h100);
        tick(); #1;
        chk("t3_occ1", 64'(occupancy), 64'd1);
        chk("t3_drop2b", 64'(dut.drop_cnt), 64'd2);
        chk("t3_addr104", imem_req_addr, B + 64'h104);
        tick(); #1;
        chk("t3_drop1", 64'(dut.drop_cnt), 64'd1);
        chk("t3_idv_drop", 64'(id_valid), 64'd0);
        chk("t3_addr108", imem_req_addr, B + 64'h108);
        tick(); #1;
        chk("t3_drop0", 64'(dut.drop_cnt), 64'd0);
        chk("t3_idv_last", 64'(id_valid), 64'd0);
        chk("t3_occ3", 64'(occupancy), 64'd3);
        tick(); #1;
        chk("t3_idv", 64'(id_valid), 64'd1);
        chk("t3_idpc", id_pc, B + 64'h100);
        chk("t3_idinst", 64'(id_inst), 64'(inst_of(B + 64'h100)));
        chk("t3_occ4", 64'(occupancy), 64'd4);

        // Clean restart with responses held back
        rst = 1'b1; rsp_en = 1'b0; id_ready = 1'b0; #1;
        tick();
        rst = 1'b0; #1;
        chk("t4_start_addr", imem_req_addr, B);
        tick(); #1;
        tick();
        rsp_en = 1'b1; #1;
        chk("t4_occ2", 64'(occupancy), 64'd2);
        tick();

        // Redirect coinciding with a response, three in flight
        redirect_valid = 1'b1; redirect_pc = B + 64'h100; rsp_en = 1'b0; #1;
        chk("t4_redir_req", 64'(imem_req_valid), 64'd0);
        chk("t4_redir_occ", 64'(occupancy), 64'd3);
        tick();
        redirect_valid = 1'b0; rsp_en = 1'b1; #1;
        chk("t4_drop2", 64'(dut.drop_cnt), 64'd2);
        chk("t4_occ0", 64'(occupancy), 64'd0);
        chk("t4_idv0", 64'(id_valid), 64'd0);
        chk("t4_addr100", imem_req_addr, B + 64'h100);
        tick();

        // Second redirect while still dropping
        redirect_valid = 1'b1; redirect_pc = B + 64'h200; #1;
        chk("t5_redir_req", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0; id_ready = 1'b1; #1;
        chk("t5_drop2", 64'(dut.drop_cnt), 64'd2);
        chk("t5_occ0", 64'(occupancy), 64'd0);
        chk("t5_addr200", imem_req_addr, B + 64'h200);
        tick(); #1;
        chk("t5_drop1", 64'(dut.drop_cnt), 64'd1);
        chk("t5_occ1", 64'(occupancy), 64'd1);
        chk("t5_idv_a", 64'(id_valid), 64'd0);
        chk("t5_addr204", imem_req_addr, B + 64'h204);
        tick(); #1;
        chk("t5_drop0", 64'(dut.drop_cnt), 64'd0);
        chk("t5_idv_b", 64'(id_valid), 64'd0);
        chk("t5_addr208", imem_req_addr, B + 64'h208);
        tick(); #1;
        chk("t5_idv", 64'(id_valid), 64'd1);
        chk("t5_idpc", id_pc, B + 64'h200);
        chk("t5_idinst", 64'(id_inst), 64'(inst_of(B + 64'h200)));
        tick();
        id_ready = 1'b0; #1;
        chk("t5_idpc2", id_pc, B + 64'h204);
        chk("t5_occ3", 64'(occupancy), 64'd3);
        tick(); #1;
        chk("t6_full_occ", 64'(occupancy), 64'd4);
        chk("t6_full_req", 64'(imem_req_valid), 64'd0);
        tick(); #1;
        chk("t6_pre_idv", 64'(id_valid), 64'd1);
        chk("t6_pre_pc", id_pc, B + 64'h204);

        // Reset pulse with a full queue
        rst = 1'b1; #1;
        chk("t6_rst_idv", 64'(id_valid), 64'd0);
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_req", 64'(imem_req_valid), 64'd0);
        chk("t6_rst_inst", 64'(id_inst), 64'(NOP_INST));
        chk("t6_rst_pc", id_pc, 64'd0);
        tick();
        rst = 1'b0; #1;
        chk("t6_rel_req", 64'(imem_req_valid), 64'd1);
        chk("t6_rel_addr", imem_req_addr, B);
        chk("t6_rel_drop", 64'(dut.drop_cnt), 64'd0);
        tick(); #1;
        chk("t6_rel_occ1", 64'(occupancy), 64'd1);
        chk("t6_rel_addr1", imem_req_addr, B + 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
